// File: rtl/and_net_sequencer_if.sv
// and_net_sequencer_if: request/response handshake bundle between a client and the sequencer
interface and_net_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] req_op;
  logic [3:0] req_mask;
  logic       abort;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic [3:0] rsp_trace;
  modport master (
    output req_valid, req_op, req_mask, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_trace
  );
  modport slave (
    input  req_valid, req_op, req_mask, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_trace
  );
endinterface

// File: rtl/and_net_sequencer.sv
// and_net_sequencer: applies operands, steps stage enables in4,in3,in1,in2 with settle time, returns outputs and t trace
module and_net_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  and_net_sequencer_if.slave        bus,
  output logic [8:0]                o_net_op,
  output logic [3:0]                o_net_en,
  input  logic                      i_net_t,
  input  logic                      i_net_n,
  input  logic                      i_net_r,
  input  logic                      i_net_k,
  input  logic                      i_net_m,
  output logic                      o_busy,
  output logic [7:0]                o_done_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_ST4, S_ST3, S_ST1, S_ST2, S_RESP} state_t;
  localparam logic [3:0] LOAD = 4'(SETTLE - 1);
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [8:0] r_op;
  logic [3:0] r_mask;
  logic [4:0] r_data;
  logic [3:0] r_trace;
  logic [7:0] r_done;
  logic [3:0] w_en_acc;
  logic [1:0] w_idx;
  logic       w_timed, w_adv;
  always_comb begin
    w_next = r_state;
    w_timed = r_state != S_IDLE && r_state != S_RESP;
    w_adv = w_timed && r_cnt == 4'd0 && !bus.abort;
    unique case (r_state)
      S_IDLE:  w_next = bus.req_valid ? S_APPLY : S_IDLE;
      S_APPLY: w_next = S_ST4;
      S_ST4:   w_next = S_ST3;
      S_ST3:   w_next = S_ST1;
      S_ST1:   w_next = S_ST2;
      S_ST2:   w_next = S_RESP;
      S_RESP:  w_next = bus.rsp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
    if (w_timed && !w_adv)
      w_next = bus.abort ? S_IDLE : r_state;
  end
  // Enables accumulate in dependency order; each bit gated by the request mask.
  always_comb begin
    w_en_acc = r_state == S_ST4 ? 4'b1000 :
               r_state == S_ST3 ? 4'b1100 :
               r_state == S_ST1 ? 4'b1101 :
               (r_state == S_ST2 || r_state == S_RESP) ? 4'b1111 : 4'b0000;
    w_idx = r_state == S_ST4 ? 2'd0 :
            r_state == S_ST3 ? 2'd1 :
            r_state == S_ST1 ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= LOAD;
      r_op    <= '0;
      r_mask  <= '0;
      r_data  <= '0;
      r_trace <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next != r_state ? LOAD : r_cnt != 4'd0 ? r_cnt - 4'd1 : r_cnt;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_op   <= bus.req_op;
        r_mask <= bus.req_mask;
      end
      if (w_adv && r_state != S_APPLY)
        r_trace[w_idx] <= i_net_t;
      if (w_adv && r_state == S_ST2)
        r_data <= {i_net_t, i_net_n, i_net_r, i_net_k, i_net_m};
      if (r_state == S_RESP && bus.rsp_ready)
        r_done <= r_done + 8'd1;
    end
  end
  assign o_net_op      = r_state == S_IDLE ? 9'd0 : r_op;
  assign o_net_en      = w_en_acc & r_mask;
  assign o_busy        = r_state != S_IDLE;
  assign o_done_cnt    = r_done;
  assign bus.req_ready = r_state == S_IDLE;
  assign bus.rsp_valid = r_state == S_RESP;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_trace = r_trace;
endmodule

// File: tb/tb_and_net_sequencer.sv
// tb_and_net_sequencer: random and directed transactions on SETTLE=1 and SETTLE=3 instances against a stage-order model
module tb_and_net_sequencer;
  logic       clk = 0;
  logic       rst = 1;
  logic       req_valid = 0, abort = 0, rsp_ready = 0, sel = 0;
  logic [8:0] req_op = '0;
  logic [3:0] req_mask = '0;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_done [2] = '{8'd0, 8'd0};
  always #5 clk = ~clk;
  and_net_sequencer_if b1();
  and_net_sequencer_if b3();
  logic [8:0] op1, op3;
  logic [3:0] en1, en3;
  logic [4:0] n1, n3;
  logic       busy1, busy3;
  logic [7:0] done1, done3;
  function automatic logic [4:0] net_f(logic [8:0] op, logic [3:0] en);
    logic a, b, c, d, e, f, g, h, i, x4, x3, x1, x2;
    {a, b, c, d, e, f, g, h, i} = op;
    x4 = en[3] & (a ^ b ^ c);
    x3 = en[2] & (x4 | (d & e));
    x1 = en[0] & (x3 ^ f);
    x2 = en[1] & (x1 | (g & h));
    return {x4 ^ x3 ^ x1 ^ x2 ^ i, x4 & x3, x1 | i, x2, x3 ^ x1};
  endfunction
  function automatic logic [3:0] en_after(int st, logic [3:0] mask);
    int order [4] = '{3, 2, 0, 1};
    logic [3:0] acc = '0;
    for (int j = 0; j <= st; j++) acc[order[j]] = 1'b1;
    return acc & mask;
  endfunction
  assign n1 = net_f(op1, en1);
  assign n3 = net_f(op3, en3);
  assign b1.req_valid = req_valid & ~sel;
  assign b3.req_valid = req_valid & sel;
  assign b1.req_op = req_op;
  assign b3.req_op = req_op;
  assign b1.req_mask = req_mask;
  assign b3.req_mask = req_mask;
  assign b1.abort = abort;
  assign b3.abort = abort;
  assign b1.rsp_ready = rsp_ready;
  assign b3.rsp_ready = rsp_ready;
  and_net_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .o_net_op(op1), .o_net_en(en1),
    .i_net_t(n1[4]), .i_net_n(n1[3]), .i_net_r(n1[2]), .i_net_k(n1[1]), .i_net_m(n1[0]),
    .o_busy(busy1), .o_done_cnt(done1));
  and_net_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3), .o_net_op(op3), .o_net_en(en3),
    .i_net_t(n3[4]), .i_net_n(n3[3]), .i_net_r(n3[2]), .i_net_k(n3[1]), .i_net_m(n3[0]),
    .o_busy(busy3), .o_done_cnt(done3));
  wire       o_rv    = sel ? b3.rsp_valid : b1.rsp_valid;
  wire       o_rr    = sel ? b3.req_ready : b1.req_ready;
  wire [4:0] o_data  = sel ? b3.rsp_data : b1.rsp_data;
  wire [3:0] o_trace = sel ? b3.rsp_trace : b1.rsp_trace;
  wire [8:0] o_op    = sel ? op3 : op1;
  wire [3:0] o_en    = sel ? en3 : en1;
  wire       o_busy  = sel ? busy3 : busy1;
  wire [7:0] o_done  = sel ? done3 : done1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s sel=%0d t=%0t got=%0h exp=%0h", tag, sel, $time, got, exp);
    end
  endtask
  task automatic run_txn(input logic [8:0] op, input logic [3:0] mask, input int hold);
    int s = sel ? 3 : 1;
    logic [3:0] tr;
    logic [4:0] dat, v;
    for (int j = 0; j < 4; j++) begin
      v = net_f(op, en_after(j, mask));
      tr[j] = v[4];
    end
    dat = net_f(op, mask);
    req_valid = 1; req_op = op; req_mask = mask; rsp_ready = (hold == 0);
    chk("req_ready_idle", o_rr, 1);
    @(posedge clk);
    @(negedge clk);
    req_op = ~op; req_mask = ~mask;
    for (int k = 0; k < 5 * s; k++) begin
      chk("busy", o_busy, 1);
      chk("req_ready_busy", o_rr, 0);
      chk("rsp_valid_early", o_rv, 0);
      chk("net_op", o_op, op);
      chk("net_en", o_en, (k / s == 0) ? 4'd0 : en_after(k / s - 1, mask));
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", o_rv, 1);
      chk("rsp_data", o_data, dat);
      chk("rsp_trace", o_trace, tr);
      chk("resp_net_op", o_op, op);
      chk("resp_net_en", o_en, mask);
      chk("resp_req_ready", o_rr, 0);
      chk("resp_done", o_done, exp_done[sel]);
      abort = (h != hold);
      if (h == hold) rsp_ready = 1;
      @(negedge clk);
    end
    exp_done[sel] = exp_done[sel] + 8'd1;
    chk("post_rsp_valid", o_rv, 0);
    chk("post_req_ready", o_rr, 1);
    chk("post_busy", o_busy, 0);
    chk("post_net_en", o_en, 0);
    chk("post_net_op", o_op, 0);
    chk("post_done", o_done, exp_done[sel]);
    chk("post_data_kept", o_data, dat);
    chk("post_trace_kept", o_trace, tr);
  endtask
  task automatic abort_txn(input logic [8:0] op, input logic [3:0] mask, input int at);
    int s = sel ? 3 : 1;
    req_valid = 1; req_op = op; req_mask = mask; rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < at; k++) @(negedge clk);
    chk("pre_abort_busy", o_busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", o_busy, 0);
    chk("abort_net_en", o_en, 0);
    chk("abort_net_op", o_op, 0);
    chk("abort_req_ready", o_rr, 1);
    for (int k = 0; k < 5 * s + 2; k++) begin
      chk("abort_no_rsp", o_rv, 0);
      @(negedge clk);
    end
    chk("abort_done", o_done, exp_done[sel]);
  endtask
  initial begin
    logic [7:0] start;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", o_rr, 1);
    chk("rst_rsp_valid", o_rv, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_net_op", o_op, 0);
    chk("rst_net_en", o_en, 0);
    chk("rst_data", o_data, 0);
    chk("rst_trace", o_trace, 0);
    chk("rst_done", o_done, 0);
    rst = 0;
    @(negedge clk);
    run_txn(9'b010000100, 4'b1111, 0);
    run_txn(9'b101111000, 4'b1111, 0);
    run_txn(9'b101111000, 4'b1101, 0);
    run_txn(9'b010000100, 4'b1111, 4);
    req_valid = 0;
    abort_txn(9'b010000100, 4'b1111, 2);
    sel = 1;
    run_txn(9'b010000100, 4'b1111, 0);
    run_txn(9'b101111000, 4'b1101, 2);
    req_valid = 0;
    abort_txn(9'b101111000, 4'b1111, 7);
    sel = 0;
    req_valid = 1; req_op = 9'h1a5; req_mask = 4'hf; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_req_ready", o_rr, 1);
    chk("arst_rsp_valid", o_rv, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_net_op", o_op, 0);
    chk("arst_net_en", o_en, 0);
    chk("arst_data", o_data, 0);
    chk("arst_trace", o_trace, 0);
    chk("arst_done", o_done, 0);
    exp_done[0] = 0; exp_done[1] = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      int s = sel ? 3 : 1;
      if ($urandom_range(0, 5) == 0) abort_txn(9'($urandom), 4'($urandom), $urandom_range(0, 5 * s - 1));
      else run_txn(9'($urandom), 4'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 0;
        repeat (2) @(negedge clk);
        chk("gap_idle", o_rr, 1);
        chk("gap_no_rsp", o_rv, 0);
      end
      req_valid = 0;
      sel = 1'($urandom_range(0, 1));
    end
    sel = 0;
    start = exp_done[0];
    for (int i = 0; i < 256; i++) run_txn(9'($urandom), 4'($urandom), 0);
    chk("done_wrap", o_done, start);
    req_valid = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
